controle_multiciclo: RTL

Multi-cycle main control FSM for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives the ALU-source select (readData2 vs. signExtend), the register-file and memory strobes, and PC update. It sits beside the datapath, reads the IR opcode and the ALU zero flag, and handshakes with instruction/data memory through a ready line.

---
 rtl/controle_multiciclo.sv | 138 +++++++++++++
 1 files changed

// File: rtl/controle_multiciclo.sv
// Multi-cycle MIPS main control: sequences fetch/decode/execute/memory/write-back,
// drives datapath strobes combinationally and counts retired instructions.
module controle_multiciclo (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        memPronto,
  output logic        sinalDoControleMux3,
  output logic [1:0]  aluOp,
  output logic        regDst,
  output logic        memToReg,
  output logic        regWrite,
  output logic        memRead,
  output logic        memWrite,
  output logic        irWrite,
  output logic        pcWrite,
  output logic        pcSrcBranch,
  output logic        jump,
  output logic        instrInvalida,
  output logic [2:0]  estado,
  output logic [15:0] contadorInstrucoes
);

  localparam logic [2:0] BUSCA      = 3'd0;
  localparam logic [2:0] DECODIFICA = 3'd1;
  localparam logic [2:0] EXECUTA    = 3'd2;
  localparam logic [2:0] MEMORIA    = 3'd3;
  localparam logic [2:0] ESCRITA    = 3'd4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [2:0] estadoAtual;
  logic [2:0] proxEstado;
  logic       retira;
  logic       opcodeValido;

  assign estado = estadoAtual;
  assign opcodeValido = (opcode == OP_R)   || (opcode == OP_LW)   || (opcode == OP_SW) ||
                        (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estadoAtual        <= BUSCA;
      contadorInstrucoes <= 16'd0;
    end else begin
      estadoAtual <= proxEstado;
      if (retira)
        contadorInstrucoes <= contadorInstrucoes + 16'd1;
    end
  end

  always_comb begin
    proxEstado = BUSCA;
    retira     = 1'b0;
    case (estadoAtual)
      BUSCA:      proxEstado = memPronto ? DECODIFICA : BUSCA;
      DECODIFICA: proxEstado = opcodeValido ? EXECUTA : BUSCA;
      EXECUTA: begin
        if (opcode == OP_LW || opcode == OP_SW)
          proxEstado = MEMORIA;
        else if (opcode == OP_R || opcode == OP_ADDI)
          proxEstado = ESCRITA;
        else if (opcode == OP_BEQ || opcode == OP_J)
          retira = 1'b1;
      end
      MEMORIA: begin
        if (!memPronto)
          proxEstado = MEMORIA;
        else if (opcode == OP_LW)
          proxEstado = ESCRITA;
        else
          retira = (opcode == OP_SW);
      end
      ESCRITA: retira = 1'b1;
      default: proxEstado = BUSCA;
    endcase
  end

  always_comb begin
    sinalDoControleMux3 = 1'b0;
    aluOp               = 2'b00;
    regDst              = 1'b0;
    memToReg            = 1'b0;
    regWrite            = 1'b0;
    memRead             = 1'b0;
    memWrite            = 1'b0;
    irWrite             = 1'b0;
    pcWrite             = 1'b0;
    pcSrcBranch         = 1'b0;
    jump                = 1'b0;
    instrInvalida       = 1'b0;
    // Everything stays quiet while reset is held, even the fetch read.
    if (!reset) begin
      case (estadoAtual)
        BUSCA: begin
          memRead = 1'b1;
          irWrite = memPronto;
          pcWrite = memPronto;
        end
        DECODIFICA: instrInvalida = !opcodeValido;
        EXECUTA: begin
          sinalDoControleMux3 = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_ADDI);
          if (opcode == OP_BEQ)
            aluOp = 2'b01;
          else if (opcode == OP_R)
            aluOp = 2'b10;
          if (opcode == OP_BEQ) begin
            pcSrcBranch = 1'b1;
            pcWrite     = zero;
          end
          if (opcode == OP_J) begin
            jump    = 1'b1;
            pcWrite = 1'b1;
          end
        end
        MEMORIA: begin
          sinalDoControleMux3 = 1'b1;
          memRead  = (opcode == OP_LW);
          memWrite = (opcode == OP_SW);
        end
        ESCRITA: begin
          regWrite            = 1'b1;
          regDst              = (opcode == OP_R);
          memToReg            = (opcode == OP_LW);
          sinalDoControleMux3 = (opcode == OP_ADDI);
        end
        default: ;
      endcase
    end
  end

endmodule
